pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and bubble-safe control-field masking. Generalises the fixed-field stage registers between pipeline stages (e.g. Memory→Writeback control fields such as RegWrite and ResultSrc) into one reusable block. The block adds stall back-pressure, bubble insertion and an optional skid entry for full throughput with a registered ready. It is instantiated at every stage boundary of the pipelined core.

## Interface
Parameters:
- WIDTH, 8, payload width in bits; range 1..256.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into all data registers on reset and on flush.
- KILL_MASK, {WIDTH{1'b1}}, payload bits forced to 0 on out_data whenever out_valid=0, so that RegWrite/MemWrite-type control bits never leak from bubbles.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream beat present.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload; bits in KILL_MASK are 0 when out_valid=0.
- flush  input  1  synchronous kill of all held and incoming beats.
- occupancy  output  2  number of held beats (0..1 without skid, 0..2 with skid).

## Operation
- A beat is accepted when in_valid && in_ready; a beat is delivered when out_valid && out_ready.
- Main entry: main_valid and main_data drive out_valid and out_data directly (registered outputs).
- Priority at each edge: reset > flush > normal transfer.
- flush=1: at the next edge main_valid=0, skid_valid=0, and data registers are loaded with RESET_VAL. A beat accepted in the flush cycle is dropped. in_ready is computed normally in that cycle.
- In-order, lossless, no duplication. Payload is never modified except by KILL_MASK gating.
- Without skid:
  - in_ready = !main_valid || out_ready (combinational from out_ready).
  - On accept, main_data <= in_data and main_valid <= 1.
  - On deliver without accept, main_valid <= 0.
- With skid (see Configuration):
  - in_ready = !skid_valid (registered; no combinational path from out_ready).
  - Accept while main is empty, or main is delivered in the same cycle: the beat goes to main.
  - Accept while main is full and stalled: the beat goes to skid.
  - Deliver while skid_valid: main <= skid and skid_valid <= 0.
  - Accept is impossible while skid_valid=1.
- occupancy = main_valid + skid_valid.

## Timing
- Reset (asynchronous assert) forces out_valid=0, main_valid=0, skid_valid=0, occupancy=0, and main_data=skid_data=RESET_VAL. Consequently out_data = RESET_VAL & ~KILL_MASK.
- Reset value of in_ready is 1 in both modes.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle in both modes when out_ready=1 continuously.
- Stall: while out_valid=1 and out_ready=0, out_data and out_valid hold stable (AXI-style rule). out_valid never drops without a delivery, flush or reset.
- Simultaneous accept and deliver with main full and skid empty: main <= in_data and the count is unchanged.
- Flush together with out_ready=1: the delivery in that cycle still counts downstream. State is empty afterwards.
- Reset mid-stall: all beats are lost. No beat is delivered until a new accept occurs.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry operation. in_ready is registered, occupancy ranges 0..2, and the skid register and its mux are present.
- PIPE_STAGE_SKID_EN undefined: single entry. in_ready = !main_valid || out_ready, occupancy[1] is tied to 0, and no skid logic is instantiated.
- The port list is identical in both builds.

## Test plan
- Reset, then check outputs: with WIDTH=8, RESET_VAL=8'hA5 and KILL_MASK=8'h0F, require out_valid=0, out_data=8'hA0, in_ready=1 and occupancy=0.
- Streaming: send beats 1..16 with out_ready=1 every cycle. Require out_data 1..16 in order, each 1 cycle after accept, with no gaps.
- Stall: send beat 8'h11 then 8'h22, and hold out_ready=0 for 5 cycles.
  - With skid: occupancy=2, in_ready=0, out_data stable at 8'h11.
  - Without skid: in_ready=0 after the first beat.
  - Release out_ready: require 8'h11 then 8'h22 with no loss.
- Flush: assert flush with occupancy=2 while in_valid=1 carries 8'h33. Next cycle require out_valid=0, occupancy=0 and out_data=RESET_VAL&~KILL_MASK; 8'h33 is never delivered.
- Random: apply random in_valid/out_ready at 50% density for 10k cycles and check against a scoreboard. Require order preserved, no drops or duplicates, and stable output under stall. Run in both macro builds.
- Async reset mid-stall: assert reset between clock edges with occupancy=2. Require immediate out_valid=0, then post-reset acceptance of a new beat 8'h44 delivered 1 cycle later.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// bubble masking. Define PIPE_STAGE_SKID_EN for a two-entry build with registered in_ready.
module pipe_stage_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] KILL_MASK = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  logic             mainValid;
  logic [WIDTH-1:0] mainData;
  logic             accept;
  logic             deliver;

  assign deliver   = mainValid && out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = mainValid;
  // Bubbles must never expose control bits such as RegWrite or MemWrite.
  assign out_data  = mainValid ? mainData : (mainData & ~KILL_MASK);

`ifdef PIPE_STAGE_SKID_EN
  logic             skidValid;
  logic [WIDTH-1:0] skidData;

  // in_ready depends only on state, so out_ready has no path to it.
  assign in_ready  = !skidValid;
  assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainData  <= RESET_VAL;
      skidData  <= RESET_VAL;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainData  <= RESET_VAL;
      skidData  <= RESET_VAL;
    end else if (accept) begin
      // skid is empty whenever accept is possible
      if (!mainValid || out_ready) begin
        mainData  <= in_data;
        mainValid <= 1'b1;
      end else begin
        skidData  <= in_data;
        skidValid <= 1'b1;
      end
    end else if (deliver) begin
      if (skidValid) begin
        mainData  <= skidData;
        skidValid <= 1'b0;
      end else begin
        mainValid <= 1'b0;
      end
    end
  end
`else
  assign in_ready  = !mainValid || out_ready;
  assign occupancy = {1'b0, mainValid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mainValid <= 1'b0;
      mainData  <= RESET_VAL;
    end else if (flush) begin
      mainValid <= 1'b0;
      mainData  <= RESET_VAL;
    end else if (accept) begin
      mainData  <= in_data;
      mainValid <= 1'b1;
    end else if (deliver) begin
      mainValid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, hand-written flush and
// async-reset sequences, then random traffic against a queue-based model.
module tb_pipe_stage_reg;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;
  localparam logic [7:0] KM = 8'h0F;
  localparam logic [7:0] BUBBLE_RV = RV & ~KM;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int compared = 0;
  int mismatched = 0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV), .KILL_MASK(KM)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       er;
    logic [1:0] eo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic ev, input logic [7:0] ed, input logic er,
                              input logic [1:0] eo);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.er = er; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOut(input string tag, input logic ev, input logic [7:0] ed,
                          input logic er, input logic [1:0] eo);
    chk({tag, "_valid"}, int'(out_valid), int'(ev));
    chk({tag, "_data"}, int'(out_data), int'(ed));
    chk({tag, "_ready"}, int'(in_ready), int'(er));
    chk({tag, "_occ"}, int'(occupancy), int'(eo));
  endtask

  // Reference model: an ordered queue of held beats.
  logic [7:0] modelQ[$];

  function automatic logic modelReady(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
    return modelQ.size() < 2;
`else
    return (modelQ.size() == 0) || ordy;
`endif
  endfunction

  initial begin
    // ---------------- vector table ----------------
    vecs.push_back(mk(0, 8'h00, 0, 0, BUBBLE_RV, 1, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 8'(i + 1), 1, i > 0, (i > 0) ? 8'(i) : BUBBLE_RV, 1, (i > 0) ? 2'd1 : 2'd0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'd16, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h10 & ~KM, 1, 0));
`ifdef PIPE_STAGE_SKID_EN
    vecs.push_back(mk(1, 8'h11, 0, 0, 8'h10 & ~KM, 1, 0));
    vecs.push_back(mk(1, 8'h22, 0, 1, 8'h11, 1, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 8'h99, 0, 1, 8'h11, 0, 2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h11, 0, 2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h22, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h22 & ~KM, 1, 0));
`else
    vecs.push_back(mk(1, 8'h11, 0, 0, 8'h10 & ~KM, 1, 0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1, 8'h22, 0, 1, 8'h11, 0, 1));
    vecs.push_back(mk(1, 8'h22, 1, 1, 8'h11, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h22, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h22 & ~KM, 1, 0));
`endif

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, 1'b0);
      #1;
      checkOut($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].er, vecs[i].eo);
      tick();
    end

    // ---------------- flush with held beats and an incoming beat ----------------
    drive(1, 8'h11, 0, 0); tick();
    drive(1, 8'h22, 0, 0); tick();
    drive(1, 8'h33, 0, 1);
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("flush_pre_occ", int'(occupancy), 2);
`else
    chk("flush_pre_occ", int'(occupancy), 1);
`endif
    tick();
    drive(0, 8'h00, 1, 0);
    #1;
    checkOut("flush_post", 0, BUBBLE_RV, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk($sformatf("flush_nodeliver%0d", i), int'(out_valid), 0);
    end
    tick();

    // ---------------- async reset mid-stall ----------------
    drive(1, 8'h11, 0, 0); tick();
    drive(1, 8'h22, 0, 0); tick();
    drive(0, 8'h00, 0, 0);
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("areset_pre_occ", int'(occupancy), 2);
`else
    chk("areset_pre_occ", int'(occupancy), 1);
`endif
    #1 reset = 1'b1;
    #1;
    checkOut("areset_now", 0, BUBBLE_RV, 1, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    drive(0, 8'h00, 1, 0);
    #1;
    chk("areset_nodeliver", int'(out_valid), 0);
    tick();
    drive(1, 8'h44, 1, 0);
    #1;
    chk("areset_ready", int'(in_ready), 1);
    tick();
    drive(0, 8'h00, 1, 0);
    #1;
    checkOut("areset_new", 1, 8'h44, 1, 1);
    tick();
    #1;
    chk("areset_drain", int'(out_valid), 0);
    tick();

    // ---------------- random traffic vs queue model ----------------
    modelQ.delete();
    for (int c = 0; c < 10000; c++) begin
      logic       iv, ordy, fl, er, acc, del;
      logic [7:0] id;
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 31) == 0);
      id   = 8'($urandom);
      drive(iv, id, ordy, fl);
      #1;
      er = modelReady(ordy);
      chk("rnd_valid", int'(out_valid), int'(modelQ.size() > 0));
      chk("rnd_ready", int'(in_ready), int'(er));
      chk("rnd_occ", int'(occupancy), modelQ.size());
      if (modelQ.size() > 0)
        chk("rnd_data", int'(out_data), int'(modelQ[0]));
      else
        chk("rnd_bubble_mask", int'(out_data & KM), 0);
      acc = iv && er;
      del = (modelQ.size() > 0) && ordy;
      tick();
      if (fl) begin
        modelQ.delete();
      end else begin
        if (del) void'(modelQ.pop_front());
        if (acc) modelQ.push_back(id);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
